// File: rtl/async_fifo_pkg.sv
// Shared pointer types and Gray-code helpers for the async FIFO write and read control blocks.
package async_fifo_pkg;

  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b = '0;
    for (int unsigned i = 0; i <= ADDR_WIDTH; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/async_fifo_sync_2ff.sv
// Generic two-flop synchronizer for Gray pointers crossing between FIFO clock domains.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/async_fifo_wptr_full.sv
// Write-domain control for the async FIFO: write pointers, synchronized read pointer,
// full / almost_full / fill level and sticky overflow.
module async_fifo_wptr_full #(
  parameter int unsigned ADDR_WIDTH = async_fifo_pkg::ADDR_WIDTH,
  parameter int unsigned AF_MARGIN  = 4
) (
  input  logic                  wclk,
  input  logic                  reset,
  input  logic                  w_en,
  input  logic [ADDR_WIDTH:0]   rptr_gray,
  output logic [ADDR_WIDTH-1:0] wadrs,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  overflow
);

  localparam int unsigned PW       = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH_W  = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AF_LEVEL = PW'(DEPTH_W - AF_MARGIN);

  logic [ADDR_WIDTH:0] wbin;
  logic [ADDR_WIDTH:0] rq2;
  logic [ADDR_WIDTH:0] rbin_sync;
  logic [ADDR_WIDTH:0] wbin_next;
  logic [ADDR_WIDTH:0] wgray_next;
  logic [ADDR_WIDTH:0] wlevel_next;
  logic [ADDR_WIDTH:0] full_match;
  logic                push;
  logic                full_next;
  logic                almost_full_next;
  logic                overflow_next;

  sync_2ff #(.WIDTH(PW)) u_rptr_sync (
    .clk   (wclk),
    .reset (reset),
    .d     (rptr_gray),
    .q     (rq2)
  );

  // Next-state pointer, level and flag computation; rptr_gray is only seen through rq2.
  always_comb begin
    push             = w_en & ~full;
    wbin_next        = wbin + PW'(push);
    wgray_next       = wbin_next ^ (wbin_next >> 1);
    rbin_sync        = '0;
    for (int unsigned i = 0; i <= ADDR_WIDTH; i++) begin
      rbin_sync[i] = ^(rq2 >> i);
    end
    wlevel_next      = wbin_next - rbin_sync;
    full_match       = {~rq2[ADDR_WIDTH:ADDR_WIDTH-1], rq2[ADDR_WIDTH-2:0]};
    full_next        = (wgray_next == full_match);
    almost_full_next = (wlevel_next >= AF_LEVEL);
    overflow_next    = overflow | (w_en & full);
  end

  always_ff @(posedge wclk) begin
    if (!reset) begin
      wbin        <= '0;
      wptr_gray   <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wlevel      <= '0;
      overflow    <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wptr_gray   <= wgray_next;
      full        <= full_next;
      almost_full <= almost_full_next;
      wlevel      <= wlevel_next;
      overflow    <= overflow_next;
    end
  end

  // Memory write in the current cycle uses the pre-increment address.
  assign wadrs = wbin[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_async_fifo_wptr_full.sv
// Directed self-checking bench for the async FIFO write-side control (ADDR_WIDTH=5, AF_MARGIN=4).
module tb_async_fifo_wptr_full;

  logic       wclk;
  logic       reset;
  logic       w_en;
  logic [5:0] rptr_gray;
  logic [4:0] wadrs;
  logic [5:0] wptr_gray;
  logic       full;
  logic       almost_full;
  logic [5:0] wlevel;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  async_fifo_wptr_full #(.ADDR_WIDTH(5), .AF_MARGIN(4)) dut (
    .wclk        (wclk),
    .reset       (reset),
    .w_en        (w_en),
    .rptr_gray   (rptr_gray),
    .wadrs       (wadrs),
    .wptr_gray   (wptr_gray),
    .full        (full),
    .almost_full (almost_full),
    .wlevel      (wlevel),
    .overflow    (overflow)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  function automatic logic [5:0] g(input logic [5:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    w_en  = 1'b1;
    repeat (3) begin
      rptr_gray = 6'($urandom);
      step();
      total++;
      if ({wadrs, wptr_gray, full, almost_full, wlevel, overflow} !== 20'd0) begin
        bad++;
        $display("FAIL reset_outputs: wadrs=%0d wptr_gray=%b full=%b af=%b wlevel=%0d ovf=%b, expected all 0",
                 wadrs, wptr_gray, full, almost_full, wlevel, overflow);
      end
    end
    rptr_gray = 6'd0;
    w_en      = 1'b0;
    reset     = 1'b1;
  endtask

  task automatic test_fill();
    logic [5:0] prev;
    w_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      total++;
      if (wadrs !== 5'(i)) begin
        bad++;
        $display("FAIL fill_wadrs: got %0d expected %0d", wadrs, i);
      end
      prev = wptr_gray;
      step();
      total++;
      if (wlevel !== 6'(i + 1)) begin
        bad++;
        $display("FAIL fill_wlevel: got %0d expected %0d", wlevel, i + 1);
      end
      total++;
      if (almost_full !== (i + 1 >= 28)) begin
        bad++;
        $display("FAIL fill_almost_full: level %0d got %b expected %b", i + 1, almost_full, (i + 1 >= 28));
      end
      total++;
      if (full !== (i == 31)) begin
        bad++;
        $display("FAIL fill_full: level %0d got %b expected %b", i + 1, full, (i == 31));
      end
      total++;
      if ($countones(prev ^ wptr_gray) > 1) begin
        bad++;
        $display("FAIL fill_gray_step: %b -> %b", prev, wptr_gray);
      end
    end
  endtask

  task automatic test_overflow();
    w_en = 1'b1;
    repeat (5) begin
      step();
      total++;
      if (wadrs !== 5'd0 || wptr_gray !== 6'b110000 || full !== 1'b1 || wlevel !== 6'd32) begin
        bad++;
        $display("FAIL overflow_hold: wadrs=%0d wptr_gray=%b full=%b wlevel=%0d, expected 0 110000 1 32",
                 wadrs, wptr_gray, full, wlevel);
      end
      total++;
      if (overflow !== 1'b1) begin
        bad++;
        $display("FAIL overflow_flag: got %b expected 1", overflow);
      end
    end
  endtask

  task automatic test_release();
    w_en      = 1'b1;
    rptr_gray = 6'b000001;
    step();
    step();
    total++;
    if (full !== 1'b1) begin
      bad++;
      $display("FAIL release_k1: full=%b expected 1", full);
    end
    step();
    total++;
    if (full !== 1'b0 || wlevel !== 6'd31 || wadrs !== 5'd0 || almost_full !== 1'b1) begin
      bad++;
      $display("FAIL release_k2: full=%b wlevel=%0d wadrs=%0d af=%b expected 0 31 0 1",
               full, wlevel, wadrs, almost_full);
    end
    step();
    total++;
    if (full !== 1'b1 || wlevel !== 6'd32 || wadrs !== 5'd1 || wptr_gray !== 6'b110001 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL release_refill: full=%b wlevel=%0d wadrs=%0d wptr_gray=%b ovf=%b expected 1 32 1 110001 1",
               full, wlevel, wadrs, wptr_gray, overflow);
    end
  endtask

  task automatic test_reset_mid_burst();
    w_en      = 1'b0;
    rptr_gray = 6'b011000;
    repeat (3) step();
    total++;
    if (wlevel !== 6'd17 || full !== 1'b0 || almost_full !== 1'b0 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL midburst_pre: wlevel=%0d full=%b af=%b ovf=%b expected 17 0 0 1",
               wlevel, full, almost_full, overflow);
    end
    w_en  = 1'b1;
    reset = 1'b0;
    step();
    total++;
    if (wlevel !== 6'd0 || full !== 1'b0 || overflow !== 1'b0 || wadrs !== 5'd0 ||
        wptr_gray !== 6'd0 || almost_full !== 1'b0) begin
      bad++;
      $display("FAIL midburst_reset: wlevel=%0d full=%b ovf=%b wadrs=%0d wptr_gray=%b af=%b expected all 0",
               wlevel, full, overflow, wadrs, wptr_gray, almost_full);
    end
    w_en      = 1'b0;
    rptr_gray = 6'd0;
    reset     = 1'b1;
  endtask

  task automatic test_random_wrap();
    logic [5:0] cnt, rd, p1, p2, prev;
    logic       we, acc, hit_full;
    int         n_writes, n_reads, cycles;
    cnt = '0; rd = '0; p1 = '0; p2 = '0;
    n_writes = 0; n_reads = 0; cycles = 0; hit_full = 1'b0;
    reset = 1'b0; w_en = 1'b0; rptr_gray = 6'd0;
    step();
    reset = 1'b1;
    while (cycles < 3000 && (n_writes < 200 || rd != cnt)) begin
      we = (n_writes < 200) && ($urandom_range(0, 3) != 0);
      if (6'(cnt - rd) != 6'd0 &&
          (((cycles % 128) < 64) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0))) begin
        rd = rd + 6'd1;
        n_reads++;
      end
      w_en      = we;
      rptr_gray = g(rd);
      acc       = we && !full;
      if (full) hit_full = 1'b1;
      prev = wptr_gray;
      step();
      cycles++;
      if (acc) begin
        cnt = cnt + 6'd1;
        n_writes++;
      end
      total++;
      if (wptr_gray !== g(cnt)) begin
        bad++;
        $display("FAIL rand_wptr: cycle %0d got %b expected %b", cycles, wptr_gray, g(cnt));
      end
      total++;
      if ($countones(prev ^ wptr_gray) > 1) begin
        bad++;
        $display("FAIL rand_gray_step: %b -> %b", prev, wptr_gray);
      end
      total++;
      if (wlevel !== 6'(cnt - p2)) begin
        bad++;
        $display("FAIL rand_wlevel: cycle %0d got %0d expected %0d", cycles, wlevel, 6'(cnt - p2));
      end
      p2 = p1;
      p1 = rd;
    end
    w_en = 1'b0;
    total++;
    if (cycles >= 3000) begin
      bad++;
      $display("FAIL rand_timeout: writes=%0d reads=%0d within 3000 cycles, expected 200 each", n_writes, n_reads);
    end
    total++;
    if (!hit_full || n_reads < 128) begin
      bad++;
      $display("FAIL rand_coverage: hit_full=%b reads=%0d expected 1 and >=128", hit_full, n_reads);
    end
  endtask

  initial begin
    reset     = 1'b0;
    w_en      = 1'b0;
    rptr_gray = 6'd0;
    test_reset();
    test_fill();
    test_overflow();
    test_release();
    test_reset_mid_burst();
    test_random_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
